serial_wide_adder: RTL and testbench

//   Adds two BYTES*8-bit operands one byte per cycle through a single 8-bit
//   p/g ripple-carry slice. The carry-out of each byte is registered and fed

---
 rtl/serial_add_pkg.sv | 18 +
 rtl/carry_chain_add8.sv | 35 +++
 rtl/serial_wide_adder.sv | 149 ++++++++++++++
 tb/tb_serial_wide_adder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared byte width and FSM state encoding for the serial adder.
// Revision    : 1.0
// ============================================================================
package serial_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/carry_chain_add8.sv
`default_nettype none
// ============================================================================
// Module      : carry_chain_add8
// Description : Combinational 8-bit propagate/generate ripple-carry slice.
// Revision    : 1.0
// ============================================================================
module carry_chain_add8
    import serial_add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] s,
    output logic              cout
);

    logic [BYTE_W-1:0] w_p;
    logic [BYTE_W-1:0] w_g;
    logic              w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    always_comb begin
        w_c = cin;
        s   = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            s[i] = w_p[i] ^ w_c;
            w_c  = w_g[i] | (w_p[i] & w_c);
        end
        cout = w_c;
    end

endmodule
`default_nettype wire

// File: rtl/serial_wide_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_wide_adder
// Description : BYTES*8-bit adder reusing one 8-bit slice, one byte per cycle,
//               with valid/ready handshakes on operands and result.
// Revision    : 1.0
// ============================================================================
module serial_wide_adder
    import serial_add_pkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BYTE_W*BYTES-1:0] a,
    input  logic [BYTE_W*BYTES-1:0] b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BYTE_W*BYTES-1:0] sum,
    output logic                  cout,
    output logic                  ovf
);

    localparam int W     = BYTE_W * BYTES;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(BYTES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [W-1:0]      r_a_sh;
    logic [W-1:0]      r_b_sh;
    logic              r_carry;
    logic [IDX_W-1:0]  r_idx;
    logic              r_a_msb;
    logic              r_b_msb;
    logic              r_out_valid;
    logic [W-1:0]      r_sum;
    logic              r_cout;
    logic              r_ovf;

    logic [BYTE_W-1:0] w_s;
    logic              w_slice_cout;
    logic [W-1:0]      w_sum_full;
    logic              w_last;

    carry_chain_add8 u_slice (
        .a    (r_a_sh[BYTE_W-1:0]),
        .b    (r_b_sh[BYTE_W-1:0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_slice_cout)
    );

    // The lowest sum byte is never stored: it is either shifted out or
    // consumed straight from the slice on the final byte.
    if (BYTES == 1) begin : g_one
        assign w_sum_full = w_s;
    end else begin : g_multi
        logic [W-BYTE_W-1:0] r_sum_sh;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sum_sh <= '0;
            end else if (r_state == ST_ADD) begin
                r_sum_sh <= w_sum_full[W-1:BYTE_W];
            end
        end

        assign w_sum_full = {w_s, r_sum_sh};
    end

    assign w_last    = (r_idx == C_LAST_IDX);
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_ADD;
            ST_ADD:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_a_msb <= a[W-1];
                        r_b_msb <= b[W-1];
                    end
                end
                ST_ADD: begin
                    r_a_sh  <= r_a_sh >> BYTE_W;
                    r_b_sh  <= r_b_sh >> BYTE_W;
                    r_carry <= w_slice_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_sum       <= w_sum_full;
                        r_cout      <= w_slice_cout;
                        r_ovf       <= (r_a_msb == r_b_msb) && (w_s[BYTE_W-1] != r_a_msb);
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_wide_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_wide_adder
// Description : Self-checking bench for serial_wide_adder (BYTES=4 and BYTES=1).
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_serial_wide_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;

    logic        in_ready4, out_valid4, cout4, ovf4;
    logic [31:0] sum4;
    logic        in_ready1, out_valid1, cout1, ovf1;
    logic [7:0]  sum1;

    logic        in_ready_m, out_valid_m, cout_m, ovf_m;
    logic [31:0] sum_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_wide_adder #(.BYTES(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid & ~sel),
        .in_ready  (in_ready4),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid4),
        .out_ready (out_ready & ~sel),
        .sum       (sum4),
        .cout      (cout4),
        .ovf       (ovf4)
    );

    serial_wide_adder #(.BYTES(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid & sel),
        .in_ready  (in_ready1),
        .a         (a[7:0]),
        .b         (b[7:0]),
        .cin       (cin),
        .out_valid (out_valid1),
        .out_ready (out_ready & sel),
        .sum       (sum1),
        .cout      (cout1),
        .ovf       (ovf1)
    );

    assign in_ready_m  = sel ? in_ready1  : in_ready4;
    assign out_valid_m = sel ? out_valid1 : out_valid4;
    assign cout_m      = sel ? cout1      : cout4;
    assign ovf_m       = sel ? ovf1       : ovf4;
    assign sum_m       = sel ? {24'd0, sum1} : sum4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (bytes=%0d): got %0h expected %0h", name, sel ? 1 : 4, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic plus the signed-overflow rule.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input int nb);
        logic [63:0] t, mask;
        logic [31:0] s;
        logic        co, ov;
        int          w;
        w    = nb * 8;
        mask = (64'd1 << w) - 64'd1;
        t    = ({32'd0, x} & mask) + ({32'd0, y} & mask) + {63'd0, c};
        s    = 32'(t & mask);
        co   = t[w];
        ov   = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
        return {ov, co, s};
    endfunction

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                          input int hold, input bit junk,
                          input logic [31:0] es, input logic ec, input logic eo);
        int n;
        int nb;
        nb = sel ? 1 : 4;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready_m && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {63'd0, in_ready_m}, 64'd1);
        @(negedge clk);
        in_valid = junk; a = $urandom; b = $urandom; cin = 1'($urandom);
        n = 0;
        while (!out_valid_m && n < 64) begin
            @(negedge clk);
            n++;
            a = $urandom; b = $urandom;
        end
        check("latency", 64'(n), 64'(nb));
        check("sum", {32'd0, sum_m}, {32'd0, es});
        check("cout", {63'd0, cout_m}, {63'd0, ec});
        check("ovf", {63'd0, ovf_m}, {63'd0, eo});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom;
            check("hold_valid", {63'd0, out_valid_m}, 64'd1);
            check("hold_sum", {32'd0, sum_m}, {32'd0, es});
            check("hold_in_ready", {63'd0, in_ready_m}, 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", {63'd0, out_valid_m}, 64'd0);
        check("release_in_ready", {63'd0, in_ready_m}, 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[7];
        logic [33:0] r;
        logic [31:0] ra, rb;
        logic        rc;

        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[4] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[6] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0};

        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_out_valid", {63'd0, out_valid_m}, 64'd0);
            check("rst_sum", {32'd0, sum_m}, 64'd0);
            check("rst_cout", {63'd0, cout_m}, 64'd0);
            check("rst_ovf", {63'd0, ovf_m}, 64'd0);
            check("rst_in_ready", {63'd0, in_ready_m}, 64'd1);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1, 1'b0, vecs[i].es, vecs[i].ec, vecs[i].eo);

        // Backpressure with in_valid held high, then a fresh op must still go through.
        run_op(32'h11111111, 32'h22222222, 1'b0, 5, 1'b1, 32'h33333333, 1'b0, 1'b0);
        run_op(32'h00000005, 32'h00000006, 1'b0, 0, 1'b0, 32'h0000000B, 1'b0, 1'b0);

        // Reset two bytes into an addition.
        @(negedge clk);
        a = 32'hDEADBEEF; b = 32'h00000001; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid_m}, 64'd0);
        check("midrst_sum", {32'd0, sum_m}, 64'd0);
        check("midrst_cout", {63'd0, cout_m}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready_m}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h0, 32'h0, 1'b1, 0, 1'b0, 32'h00000001, 1'b0, 1'b0);

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int k = 0; k < 1000; k++) begin
                ra = $urandom; rb = $urandom; rc = 1'($urandom);
                if (k % 10 == 0) ra = 32'hFFFFFFFF;
                r = model(ra, rb, rc, sel ? 1 : 4);
                run_op(ra, rb, rc, int'($urandom_range(0, 3)), 1'($urandom), r[31:0], r[32], r[33]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
